spi_register_bridge: RTL
========================

// Module: spi_register_bridge
// PURPOSE
//  SPI target (mode 0) in front of the synth core. It deserialises 24-bit host frames into
//  single-cycle register writes (RegisterWriteEnable/Number/Value) for the synth config path.
//  It also serialises the most recent 16-bit output sample back to the host on MISO.
//  All SPI pins are oversampled in the i_Clock domain; i_Clock >= 8x SCLK is required.
// PARAMETERS
//  SYNC_STAGES   2   flip-flop stages on SCLK/CS_n/MOSI before edge detection (>=2)
//  NUMBER_WIDTH  16  register-number field width (frame bits 23..8)
//  VALUE_WIDTH   8   register-value field width (frame bits 7..0)
//  SAMPLE_WIDTH  16  sample width shifted out on MISO
// PORTS
//  i_Clock               in   1   system clock, all logic on posedge
//  i_Reset_n             in   1   asynchronous, active-low reset
//  i_SpiClock            in   1   SCLK from host, idles low (CPOL=0)
//  i_SpiChipSelect_n     in   1   frame select, active low
//  i_SpiMosi             in   1   host data, sampled on SCLK rising edge
//  o_SpiMiso             out  1   sample data, changes on SCLK falling edge
//  o_RegisterWriteEnable out  1   one-cycle write strobe
//  o_RegisterWriteNumber out  16  register number, valid while strobe high
//  o_RegisterWriteValue  out  8   register value, valid while strobe high
//  i_Sample              in   16  signed sample from the synth output stage
//  i_SampleReady         in   1   one-cycle strobe: i_Sample is valid
//  o_FrameError          out  1   one-cycle pulse: frame closed with bit count != 24
// BEHAVIOUR
//  Reset: all outputs 0; sync chains load idle levels (SCLK=0, CS_n=1); state IDLE.
//    Holding register and shift registers are cleared to 0.
//  Edge detection uses the last two sync stages only: rise = prev 0 & cur 1; fall = prev 1 & cur 0.
//  Holding reg: loads i_Sample on every i_SampleReady, regardless of FSM state.
//  FSM IDLE -> SHIFT on synced CS_n fall.
//    Bit counter (5b) clears to 0.
//    MISO shifter loads the holding reg. If i_SampleReady is high that same cycle, it loads i_Sample instead.
//    o_SpiMiso = shifter MSB from the next cycle.
//  SHIFT, SCLK rise: rx_shift = {rx_shift[22:0], MOSI}.
//    count increments and saturates at 31; no further shifting once count >= 24.
//  SHIFT, SCLK fall: MISO shifter shifts left, filling with 0.
//    Bits 16..23 of the frame therefore read 0.
//  SHIFT -> COMMIT on synced CS_n rise (a rise and any SCLK edge seen in the same cycle: the CS_n rise wins).
//  COMMIT (one cycle), then -> IDLE:
//    count == 24: o_RegisterWriteEnable=1, Number=rx[23:8], Value=rx[7:0].
//    count != 24: o_FrameError=1; no write; Number/Value keep their previous values.
//  Latency: the write strobe is high exactly 1 cycle, SYNC_STAGES+2 cycles after raw CS_n rises.
//  Number/Value hold their last committed values until the next commit.
//  o_SpiMiso is driven 0 in IDLE/COMMIT; it is undriven-safe (never X).
//  SCLK edges while CS_n is high are ignored. A CS_n pulse with 0 bits yields o_FrameError.
//  Async reset mid-frame: the frame is aborted and no strobe is issued.
//    After reset, a frame already in progress (CS_n low) is not joined; wait for the next CS_n fall.
//  Back-to-back frames: a CS_n high time of >= SYNC_STAGES+2 i_Clock cycles is guaranteed to commit.
// TESTING
//  1 Frame 0xC00C_5A (24 bits, SCLK=i_Clock/8) -> one strobe, Number=0xC00C, Value=0x5A,
//    4 cycles after CS_n rises.
//  2 i_Sample=0x8123 + i_SampleReady, then frame -> MISO bits 0..15 = 1000_0001_0010_0011, bits 16..23 = 0.
//  3 Frame of 23 bits, then a frame of 25 bits -> two o_FrameError pulses, no strobes, Number/Value unchanged.
//  4 i_SampleReady in the same cycle as CS_n fall with i_Sample=0x7FFF -> MISO shifts 0x7FFF.
//  5 Assert i_Reset_n low after 12 bits -> all outputs 0, no strobe;
//    next full frame 0x8002_01 -> strobe, Number=0x8002, Value=0x01.
//  6 Two back-to-back frames 0xC100_11, 0xC101_22 with min CS_n gap -> two strobes in order, correct fields.

Source files
------------

// File: rtl/spi_register_bridge.sv
// SPI mode-0 target: 24-bit host frames become single-cycle register writes,
// and the latest output sample is shifted back on MISO. All pins are oversampled on i_Clock.
//
// state    | meaning
// ST_IDLE  | waiting for a chip-select fall (only once armed after reset)
// ST_SHIFT | frame open: MOSI shifts in on SCLK rise, MISO shifts out on SCLK fall
// ST_COMMIT| frame closed: issue write strobe or frame error, then return to idle
module spi_register_bridge #(
    parameter int SYNC_STAGES  = 2,
    parameter int NUMBER_WIDTH = 16,
    parameter int VALUE_WIDTH  = 8,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_n,
    input  logic                    i_SpiClock,
    input  logic                    i_SpiChipSelect_n,
    input  logic                    i_SpiMosi,
    output logic                    o_SpiMiso,
    output logic                    o_RegisterWriteEnable,
    output logic [NUMBER_WIDTH-1:0] o_RegisterWriteNumber,
    output logic [VALUE_WIDTH-1:0]  o_RegisterWriteValue,
    input  logic [SAMPLE_WIDTH-1:0] i_Sample,
    input  logic                    i_SampleReady,
    output logic                    o_FrameError
);

    localparam int         FRAME_WIDTH = NUMBER_WIDTH + VALUE_WIDTH;
    localparam logic [4:0] FRAME_BITS  = 5'(FRAME_WIDTH);
    localparam logic [4:0] COUNT_MAX   = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]  flush_q, flush_d;
    logic                    sclk_rise_q, sclk_rise_d;
    logic                    sclk_fall_q, sclk_fall_d;
    logic                    cs_rise_q, cs_rise_d;
    logic                    cs_fall_q, cs_fall_d;
    logic                    armed_q, armed_d;
    logic [4:0]              count_q, count_d;
    logic [FRAME_WIDTH-1:0]  rx_q, rx_d;
    logic [SAMPLE_WIDTH-1:0] tx_q, tx_d;
    logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
    logic                    miso_q, miso_d;
    logic                    wr_en_q, wr_en_d;
    logic [NUMBER_WIDTH-1:0] wr_num_q, wr_num_d;
    logic [VALUE_WIDTH-1:0]  wr_val_q, wr_val_d;
    logic                    frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        wr_en_d     = 1'b0;
        wr_num_d    = wr_num_q;
        wr_val_d    = wr_val_q;
        frame_err_d = 1'b0;

        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_SpiClock};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SpiChipSelect_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SpiMosi};
        flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};

        sclk_rise_d = sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
        cs_rise_d   = cs_sync_q[SYNC_STAGES-2] & ~cs_sync_q[SYNC_STAGES-1];
        cs_fall_d   = ~cs_sync_q[SYNC_STAGES-2] & cs_sync_q[SYNC_STAGES-1];

        // Only arm once real CS_n samples have flushed the reset values and show
        // the bus idle, so a frame already running at reset release is skipped.
        armed_d = armed_q | (flush_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES-1]
                             & cs_sync_q[SYNC_STAGES-2]);

        hold_d = i_SampleReady ? i_Sample : hold_q;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && cs_fall_q) begin
                    state_d = ST_SHIFT;
                    count_d = 5'd0;
                    tx_d    = i_SampleReady ? i_Sample : hold_q;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_q) begin
                    state_d = ST_COMMIT;
                end else begin
                    if (sclk_rise_q) begin
                        if (count_q < FRAME_BITS) begin
                            rx_d = {rx_q[FRAME_WIDTH-2:0], mosi_sync_q[SYNC_STAGES-1]};
                        end
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + 5'd1;
                        end
                    end
                    if (sclk_fall_q) begin
                        tx_d = {tx_q[SAMPLE_WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (count_q == FRAME_BITS) begin
                    wr_en_d  = 1'b1;
                    wr_num_d = rx_q[FRAME_WIDTH-1:VALUE_WIDTH];
                    wr_val_d = rx_q[VALUE_WIDTH-1:0];
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        miso_d = (state_d == ST_SHIFT) ? tx_d[SAMPLE_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            armed_q     <= 1'b0;
            count_q     <= 5'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            miso_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_num_q    <= '0;
            wr_val_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            flush_q     <= flush_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            armed_q     <= armed_d;
            count_q     <= count_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            miso_q      <= miso_d;
            wr_en_q     <= wr_en_d;
            wr_num_q    <= wr_num_d;
            wr_val_q    <= wr_val_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_SpiMiso             = miso_q;
    assign o_RegisterWriteEnable = wr_en_q;
    assign o_RegisterWriteNumber = wr_num_q;
    assign o_RegisterWriteValue  = wr_val_q;
    assign o_FrameError          = frame_err_q;

endmodule
